fir_poly_cfg: RTL and testbench

Configuration controller for the polyphase FIR (`fir_poly`). It receives a coefficient and delay set over a 32-bit AXI-stream config port and assembles it in a shadow bank. On a complete, well-framed set it swaps the bank atomically onto `coef_flat`/`delay_flat`, then masks filter output valid for a flush window so that no output sample mixes old and new coefficients. It sits between the control/DMA side and `fir_poly`, driving the filter's static configuration buses and gating its `m_axis_tvalid`.

---
 rtl/fir_poly_cfg_if.sv | 12 +
 rtl/fir_poly_cfg.sv | 174 +++++++++++++++++
 tb/tb_fir_poly_cfg.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_poly_cfg_if.sv
// AXI-stream config port carrying coefficient/delay words into fir_poly_cfg.
// Handshake: a word transfers on a rising clk edge where tvalid & tready are both high;
// the master holds tdata/tlast stable while tvalid is high and tready is low.
interface fir_poly_cfg_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/fir_poly_cfg.sv
// Config controller for fir_poly: assembles a coefficient/delay set in a shadow bank,
// swaps it live atomically and masks filter output valid while the pipeline flushes.
module fir_poly_cfg #(
  parameter int COEF_WIDTH   = 32,
  parameter int TAPS         = 4,
  parameter int PHASES       = 2,
  parameter int DELAY_WIDTH  = 16,
  parameter int FLUSH_CYCLES = 8
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  fir_poly_cfg_if.slave                      s_cfg,
  output logic [COEF_WIDTH*TAPS*PHASES-1:0]  coef_flat,
  output logic [DELAY_WIDTH*(PHASES-1)-1:0]  delay_flat,
  input  logic                               fir_m_tvalid,
  output logic                               m_axis_tvalid,
  input  logic                               err_clr,
  output logic                               cfg_error,
  output logic                               cfg_done,
  output logic                               busy,
  output logic [1:0]                         state_dbg
);

  localparam int TP   = TAPS * PHASES;
  localparam int N    = TP + PHASES - 1;
  localparam int IW   = $clog2(N + 1);
  localparam int CNTW = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam int CFW  = COEF_WIDTH * TP;
  localparam int DFW  = DELAY_WIDTH * (PHASES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SWAP  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   idx, idx_nxt;
  logic [CNTW-1:0] cnt, cnt_nxt;
  logic [CFW-1:0]  shadow_coef;
  logic [DFW-1:0]  shadow_delay;
  logic            tready_int;
  logic            accept;
  logic            wr_en;
  logic [IW-1:0]   wr_idx;
  logic            err_set;
  logic            swap_en;
  logic            done_set;
  logic            done_pend;

  assign tready_int    = ((state == ST_IDLE) || (state == ST_LOAD)) && aresetn;
  assign accept        = s_cfg.tvalid && tready_int;
  assign s_cfg.tready  = tready_int;
  assign m_axis_tvalid = fir_m_tvalid && (state != ST_SWAP) && (state != ST_FLUSH) && aresetn;
  assign busy          = (state != ST_IDLE);
  assign state_dbg     = state;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    wr_en     = 1'b0;
    wr_idx    = idx;
    err_set   = 1'b0;
    swap_en   = 1'b0;
    done_set  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          wr_en  = 1'b1;
          wr_idx = '0;
          if (s_cfg.tlast) begin
            err_set = 1'b1;
            idx_nxt = '0;
          end else begin
            idx_nxt   = IW'(1);
            state_nxt = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (accept) begin
          wr_en = 1'b1;
          if (idx == IW'(N - 1)) begin
            idx_nxt = '0;
            if (s_cfg.tlast) begin
              state_nxt = ST_SWAP;
            end else begin
              err_set   = 1'b1;
              state_nxt = ST_IDLE;
            end
          end else if (s_cfg.tlast) begin
            err_set   = 1'b1;
            idx_nxt   = '0;
            state_nxt = ST_IDLE;
          end else begin
            idx_nxt = idx + IW'(1);
          end
        end
      end
      ST_SWAP: begin
        swap_en = 1'b1;
        if (FLUSH_CYCLES == 0) begin
          done_set  = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt   = CNTW'(FLUSH_CYCLES);
          state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        cnt_nxt = cnt - CNTW'(1);
        if (cnt == CNTW'(1)) begin
          done_set  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= ST_IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Shadow bank takes every accepted word; only SWAP copies it to the live buses.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      shadow_coef  <= '0;
      shadow_delay <= '0;
      coef_flat    <= '0;
      delay_flat   <= '0;
    end else begin
      for (int k = 0; k < TP; k++) begin
        if (wr_en && (wr_idx == IW'(k)))
          shadow_coef[k*COEF_WIDTH +: COEF_WIDTH] <= s_cfg.tdata[COEF_WIDTH-1:0];
      end
      for (int k = 0; k < PHASES - 1; k++) begin
        if (wr_en && (wr_idx == IW'(TP + k)))
          shadow_delay[k*DELAY_WIDTH +: DELAY_WIDTH] <= s_cfg.tdata[DELAY_WIDTH-1:0];
      end
      if (swap_en) begin
        coef_flat  <= shadow_coef;
        delay_flat <= shadow_delay;
      end
    end
  end

  // done_pend marks the edge into IDLE; cfg_done follows one cycle later.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cfg_error <= 1'b0;
      done_pend <= 1'b0;
      cfg_done  <= 1'b0;
    end else begin
      if (err_set)
        cfg_error <= 1'b1;
      else if (err_clr)
        cfg_error <= 1'b0;
      done_pend <= done_set;
      cfg_done  <= done_pend;
    end
  end

endmodule

// File: tb/tb_fir_poly_cfg.sv
// Directed bench for fir_poly_cfg: default DUT (FLUSH_CYCLES=8) plus a FLUSH_CYCLES=0 variant.
module tb_fir_poly_cfg;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic         fir_m_tvalid;
  logic         err_clr;

  logic [255:0] coef_flat, coef1_flat;
  logic [15:0]  delay_flat, delay1_flat;
  logic         m_axis_tvalid, m1_axis_tvalid;
  logic         cfg_error, cfg1_error;
  logic         cfg_done, cfg1_done;
  logic         busy, busy1;
  logic [1:0]   state_dbg, state1_dbg;

  fir_poly_cfg_if cfg_if();
  fir_poly_cfg_if cfg1_if();

  always #5 aclk = ~aclk;

  fir_poly_cfg u_dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_cfg         (cfg_if),
    .coef_flat     (coef_flat),
    .delay_flat    (delay_flat),
    .fir_m_tvalid  (fir_m_tvalid),
    .m_axis_tvalid (m_axis_tvalid),
    .err_clr       (err_clr),
    .cfg_error     (cfg_error),
    .cfg_done      (cfg_done),
    .busy          (busy),
    .state_dbg     (state_dbg)
  );

  fir_poly_cfg #(.FLUSH_CYCLES(0)) u_dut_f0 (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_cfg         (cfg1_if),
    .coef_flat     (coef1_flat),
    .delay_flat    (delay1_flat),
    .fir_m_tvalid  (fir_m_tvalid),
    .m_axis_tvalid (m1_axis_tvalid),
    .err_clr       (err_clr),
    .cfg_error     (cfg1_error),
    .cfg_done      (cfg1_done),
    .busy          (busy1),
    .state_dbg     (state1_dbg)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0]  w [9];
  logic [255:0] exp_a, exp_b;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Drives w[0..n-1]; tlast on index last_at (-1 for none). Returns 1ns after the final accept edge.
  task automatic send_set(input int n, input int last_at, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        cfg_if.tvalid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
      end
      cfg_if.tdata  = w[i];
      cfg_if.tlast  = (i == last_at);
      cfg_if.tvalid = 1'b1;
      for (int b = 0; b < 40 && !cfg_if.tready; b++) begin @(posedge aclk); #1; end
      if (!cfg_if.tready) check("tready_timeout", cfg_if.tready, 1);
      @(posedge aclk); #1;
    end
    cfg_if.tvalid = 1'b0;
    cfg_if.tlast  = 1'b0;
  endtask

  // Observes 12 cycles after the final accept: mask length, first unmasked cycle, cfg_done timing.
  task automatic watch(input int exp_mask, input int exp_done_c, input logic [255:0] exp_coef,
                       input logic [15:0] exp_delay, input string tag);
    int masked = 0, first_open = -1, done_c = -1, done_n = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge aclk);
      if (!m_axis_tvalid) masked++;
      else if (first_open < 0) first_open = c;
      if (cfg_done) begin
        done_n++;
        if (done_c < 0) done_c = c;
      end
      if (c == 1) begin
        check($sformatf("%s_coef", tag), coef_flat, exp_coef);
        check($sformatf("%s_delay", tag), delay_flat, exp_delay);
      end
      if (c == exp_mask) begin
        check($sformatf("%s_busy_end", tag), busy, 0);
        check($sformatf("%s_tready_end", tag), cfg_if.tready, 1);
      end
    end
    check($sformatf("%s_mask_len", tag), masked, exp_mask);
    check($sformatf("%s_first_open", tag), first_open, exp_mask);
    check($sformatf("%s_done_cycle", tag), done_c, exp_done_c);
    check($sformatf("%s_done_count", tag), done_n, (exp_done_c < 0) ? 0 : 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    exp_a = {128'h0, 32'h00000100, 32'h00000010, 32'h00000001, 32'h00000000};
    exp_b = {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555,
             32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

    aresetn        = 1'b0;
    fir_m_tvalid   = 1'b1;
    err_clr        = 1'b0;
    cfg_if.tdata   = '0;
    cfg_if.tvalid  = 1'b0;
    cfg_if.tlast   = 1'b0;
    cfg1_if.tdata  = '0;
    cfg1_if.tvalid = 1'b0;
    cfg1_if.tlast  = 1'b0;

    #12;
    check("rst_tready", cfg_if.tready, 0);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_coef", coef_flat, 0);
    check("rst_delay", delay_flat, 0);
    check("rst_busy", busy, 0);
    check("rst_error", cfg_error, 0);
    check("rst_done", cfg_done, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    check("idle_tready", cfg_if.tready, 1);
    check("idle_state", state_dbg, 0);
    check("idle_m_tvalid", m_axis_tvalid, 1);

    // Default set, back-to-back.
    w[0] = 32'h0; w[1] = 32'h1; w[2] = 32'h10; w[3] = 32'h100;
    w[4] = 32'h0; w[5] = 32'h0; w[6] = 32'h0; w[7] = 32'h0; w[8] = 32'h5;
    send_set(9, 8, 1'b0);
    check("load_a_busy_swap", busy, 1);
    watch(9, 10, exp_a, 16'h0005, "load_a");

    // Early tlast on word 5.
    for (int i = 0; i < 9; i++) w[i] = 32'hDEAD0000 + i;
    send_set(5, 4, 1'b0);
    check("early_error", cfg_error, 1);
    watch(0, -1, exp_a, 16'h0005, "early");

    // Good set with random tvalid gaps; low 16 bits only reach the delay.
    for (int i = 0; i < 8; i++) w[i] = 32'h11111111 * (i + 1);
    w[8] = 32'hABCD1234;
    send_set(9, 8, 1'b1);
    watch(9, 10, exp_b, 16'h1234, "load_b");
    check("error_sticky", cfg_error, 1);
    err_clr = 1'b1;
    @(posedge aclk); #1;
    err_clr = 1'b0;
    check("err_clr_alone", cfg_error, 0);

    // Missing tlast on word 9.
    for (int i = 0; i < 9; i++) w[i] = 32'hBEEF0000 + i;
    send_set(9, -1, 1'b0);
    check("no_last_error", cfg_error, 1);
    watch(0, -1, exp_b, 16'h1234, "no_last");
    err_clr = 1'b1;
    @(posedge aclk); #1;
    err_clr = 1'b0;
    check("err_clr_again", cfg_error, 0);

    // tlast on the very first word with err_clr in the same cycle: set wins.
    w[0] = 32'hCAFE0000;
    err_clr = 1'b1;
    send_set(1, 0, 1'b0);
    err_clr = 1'b0;
    check("set_wins_error", cfg_error, 1);
    check("set_wins_coef", coef_flat, exp_b);

    // Asynchronous reset in the middle of FLUSH.
    w[0] = 32'h0; w[1] = 32'h1; w[2] = 32'h10; w[3] = 32'h100;
    w[4] = 32'h0; w[5] = 32'h0; w[6] = 32'h0; w[7] = 32'h0; w[8] = 32'h5;
    send_set(9, 8, 1'b0);
    repeat (3) @(posedge aclk);
    #2;
    check("flush_busy", busy, 1);
    check("flush_coef", coef_flat, exp_a);
    aresetn = 1'b0;
    #1;
    check("async_coef", coef_flat, 0);
    check("async_delay", delay_flat, 0);
    check("async_busy", busy, 0);
    check("async_error", cfg_error, 0);
    check("async_tready", cfg_if.tready, 0);
    check("async_m_tvalid", m_axis_tvalid, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    check("post_rst_tready", cfg_if.tready, 1);
    begin
      int dn = 0;
      for (int c = 0; c < 12; c++) begin
        @(negedge aclk);
        if (cfg_done) dn++;
      end
      check("post_rst_no_done", dn, 0);
    end

    // FLUSH_CYCLES=0 variant: 1-cycle mask, cfg_done two cycles after last accept.
    @(posedge aclk); #1;
    for (int i = 0; i < 8; i++) w[i] = 32'h11111111 * (i + 1);
    w[8] = 32'hABCD1234;
    for (int i = 0; i < 9; i++) begin
      cfg1_if.tdata  = w[i];
      cfg1_if.tlast  = (i == 8);
      cfg1_if.tvalid = 1'b1;
      @(posedge aclk); #1;
    end
    cfg1_if.tvalid = 1'b0;
    cfg1_if.tlast  = 1'b0;
    begin
      int masked = 0, first_open = -1, done_c = -1;
      for (int c = 0; c < 6; c++) begin
        @(negedge aclk);
        if (!m1_axis_tvalid) masked++;
        else if (first_open < 0) first_open = c;
        if (cfg1_done && done_c < 0) done_c = c;
        if (c == 1) begin
          check("f0_coef", coef1_flat, exp_b);
          check("f0_delay", delay1_flat, 16'h1234);
          check("f0_tready", cfg1_if.tready, 1);
        end
      end
      check("f0_mask_len", masked, 1);
      check("f0_first_open", first_open, 1);
      check("f0_done_cycle", done_c, 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
